// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO draining to RAM with youngest-match load forwarding
//
// Purpose: queues CPU stores and writes them to the RAM write port one word per
// cycle. Loads are answered from the youngest queued store to the same address,
// or from the RAM read port when nothing in the queue matches.
//
// Ports:
//   clock, reset          clock; asynchronous active-high reset
//   st_valid/st_adr/
//   st_value/st_ready     store push handshake (push when st_valid && st_ready)
//   ld_adr/ld_value       combinational load lookup
//   hold                  pauses draining while high
//   empty/count           occupancy status (registered state only)
//   wadr/wvalue/wenable   RAM write port (RAM samples on negedge)
//   radr/rvalue           RAM combinational read port
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [0:31]              st_adr,
   input  logic [0:31]              st_value,
   output logic                     st_ready,
   input  logic [0:31]              ld_adr,
   output logic [0:31]              ld_value,
   input  logic                     hold,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [0:31]              wadr,
   output logic [0:31]              wvalue,
   output logic                     wenable,
   output logic [0:31]              radr,
   input  logic [0:31]              rvalue
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;

   // Entry storage carries no reset: occupancy alone decides which entries are live.
   logic [0:31] mem_adr_q [DEPTH];
   logic [0:31] mem_val_q [DEPTH];

   logic push;
   logic pop;

   assign empty    = (count_q == '0);
   assign st_ready = (count_q != FULL);
   assign count    = count_q;
   assign push     = st_valid && st_ready;
   assign pop      = !empty && !hold;
   assign wenable  = pop;
   assign wadr     = empty ? 32'h0 : mem_adr_q[head_q];
   assign wvalue   = empty ? 32'h0 : mem_val_q[head_q];
   assign radr     = ld_adr;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Walk occupied entries oldest to youngest; later hits overwrite earlier ones,
   // so the youngest matching store wins. The head entry being drained still counts.
   always_comb begin
      logic          hit;
      logic [0:31]   fwd;
      logic [AW-1:0] idx;
      hit = 1'b0;
      fwd = 32'h0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if (((AW+1)'(i) < count_q) && (mem_adr_q[idx] == ld_adr)) begin
            hit = 1'b1;
            fwd = mem_val_q[idx];
         end
      end
      ld_value = hit ? fwd : rvalue;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_adr_q[tail_q] <= st_adr;
         mem_val_q[tail_q] <= st_value;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer against a queue model
module tb_store_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_adr;
   logic [31:0] st_value;
   logic        st_ready;
   logic [31:0] ld_adr;
   logic [31:0] ld_value;
   logic        hold;
   logic        empty;
   logic [2:0]  count;
   logic [31:0] wadr;
   logic [31:0] wvalue;
   logic        wenable;
   logic [31:0] radr;
   logic [31:0] rvalue;

   logic [31:0] ram [256];
   ent_t        q_model [$];
   ent_t        wlog [$];
   ent_t        exp_wlog [$];
   int          n_cmp = 0;
   int          n_fail = 0;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .st_valid (st_valid),
      .st_adr   (st_adr),
      .st_value (st_value),
      .st_ready (st_ready),
      .ld_adr   (ld_adr),
      .ld_value (ld_value),
      .hold     (hold),
      .empty    (empty),
      .count    (count),
      .wadr     (wadr),
      .wvalue   (wvalue),
      .wenable  (wenable),
      .radr     (radr),
      .rvalue   (rvalue)
   );

   always #5 clock = ~clock;

   assign rvalue = ram[radr[7:0]];

   always @(negedge clock) begin
      if (wenable) begin
         ram[wadr[7:0]] <= wvalue;
         wlog.push_back('{a: wadr, d: wvalue});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_ld(input logic [31:0] a);
      for (int i = q_model.size() - 1; i >= 0; i--) begin
         if (q_model[i].a == a) return q_model[i].d;
      end
      return ram[a[7:0]];
   endfunction

   // Drive one cycle's inputs just after posedge, check before the negedge RAM
   // write, then advance the model at the next posedge.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic h, input logic [31:0] la);
      int  sz;
      logic exp_wen;
      st_valid = v;
      st_adr   = a;
      st_value = d;
      hold     = h;
      ld_adr   = la;
      #3;
      sz      = q_model.size();
      exp_wen = (sz > 0) && !h;
      chk("count",    32'(count),    32'(sz));
      chk("st_ready", 32'(st_ready), 32'(sz < DEPTH));
      chk("empty",    32'(empty),    32'(sz == 0));
      chk("wenable",  32'(wenable),  32'(exp_wen));
      chk("wadr",     wadr,   (sz > 0) ? q_model[0].a : 32'h0);
      chk("wvalue",   wvalue, (sz > 0) ? q_model[0].d : 32'h0);
      chk("radr",     radr,   la);
      chk("ld_value", ld_value, model_ld(la));
      @(posedge clock);
      if (exp_wen) exp_wlog.push_back(q_model.pop_front());
      if (v && sz < DEPTH) q_model.push_back('{a: a, d: d});
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"},   32'(count),    32'h0);
      chk({tag, "_ready"},   32'(st_ready), 32'h1);
      chk({tag, "_empty"},   32'(empty),    32'h1);
      chk({tag, "_wenable"}, 32'(wenable),  32'h0);
      chk({tag, "_wadr"},    wadr,          32'h0);
      chk({tag, "_wvalue"},  wvalue,        32'h0);
      chk({tag, "_ld"},      ld_value,      ram[ld_adr[7:0]]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h5000_0000 + 32'(i);
      reset    = 1'b1;
      st_valid = 1'b0;
      st_adr   = '0;
      st_value = '0;
      hold     = 1'b0;
      ld_adr   = 32'h7;
      #12;
      check_reset_outputs("rst0");
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Single store then load
      step(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h10);
      chk("single_wadr_pre", wadr, 32'h10);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);
      chk("single_ram", ram[8'h10], 32'hDEADBEEF);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h10);

      // Fill and full, ignored fifth store, then drain in order
      for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b1, 32'(i));
      chk("full_count", 32'(count), 32'h4);
      chk("full_ready", 32'(st_ready), 32'h0);
      step(1'b1, 32'h9, 32'hBAD, 1'b1, 32'h9);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'(i));
      chk("no_adr9", ram[9], 32'h5000_0009);

      // Youngest-wins forwarding
      step(1'b1, 32'h5, 32'h1, 1'b1, 32'h5);
      step(1'b1, 32'h5, 32'h2, 1'b1, 32'h5);
      step(1'b1, 32'h6, 32'h3, 1'b1, 32'h5);
      chk("fwd5", ld_value, 32'h2);
      step(1'b0, 32'h0, 32'h0, 1'b1, 32'h6);
      step(1'b0, 32'h0, 32'h0, 1'b1, 32'h7);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h5);
      chk("ram5", ram[5], 32'h2);

      // Back-to-back streaming with wrap-around
      for (int i = 0; i < 10; i++) step(1'b1, 32'h20 + 32'(i), 32'hC00 + 32'(i), 1'b0, 32'h20 + 32'(i));
      chk("stream_count", 32'(count), 32'h1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h29);

      // Reset mid-drain: queued stores must never be written
      for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i), 32'hE00 + 32'(i), 1'b1, 32'h40);
      st_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("rstmid");
      reset = 1'b0;
      q_model.delete();
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h40 + 32'(i));
      chk("rst_ram40", ram[8'h40], 32'h5000_0040);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 9) < 3), 32'($urandom_range(0, 15)));
      end
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      chk("wlog_size", 32'(wlog.size()), 32'(exp_wlog.size()));
      for (int i = 0; i < exp_wlog.size() && i < wlog.size(); i++) begin
         chk("wlog_adr", wlog[i].a, exp_wlog[i].a);
         chk("wlog_val", wlog[i].d, exp_wlog[i].d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side buffer between the CPU memory stage and `random_access_memory`. It queues stores in a FIFO and drains them into the RAM write port at one word per cycle. Loads are served combinationally from the newest matching queued store; if no entry matches, the RAM read port is used. The CPU never stalls on a store unless the queue is full.

## Interface
Parameters:
- `DEPTH`, default 4: number of store entries. Must be a power of two and at least 2.

Ports:
- `clock`  in  1: single clock; all state updates on posedge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `st_valid`  in  1: CPU presents a store this cycle.
- `st_adr`  in  [0:31]: store word address.
- `st_value`  in  [0:31]: store data.
- `st_ready`  out  1: buffer can accept a store; equals not-full.
- `ld_adr`  in  [0:31]: load word address.
- `ld_value`  out  [0:31]: load result (forwarded or from RAM).
- `hold`  in  1: pauses draining while high.
- `empty`  out  1: no pending stores.
- `count`  out  [log2(DEPTH):0]: number of occupied entries.
- `wadr`  out  [0:31]: RAM write address.
- `wvalue`  out  [0:31]: RAM write data.
- `wenable`  out  1: RAM write enable (RAM samples on negedge).
- `radr`  out  [0:31]: RAM read address; equals `ld_adr`.
- `rvalue`  in  [0:31]: RAM combinational read data.

## Operation
- **Storage.** Circular FIFO of `DEPTH` entries, each holding {adr, value}. Uses head and tail pointers of log2(DEPTH) bits that wrap modulo `DEPTH`, plus `count`.
- **Push.** Occurs when `st_valid && st_ready` at posedge: write the entry at tail, then tail+1.
  - `st_valid` while full is ignored. The CPU must hold the store until `st_ready` is high.
- **Drain.**
  - `wenable = !empty && !hold`.
  - `wadr` and `wvalue` come from the head entry. They are driven as 0 when empty.
  - Pop (head+1) at posedge whenever `wenable` was high in that cycle.
- **Count update.**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, with both pointers advancing.
  - Push and pop together is allowed whenever not full. When full there is no push, even if a pop occurs that cycle.
- **Load forwarding.**
  - `ld_value` is the value of the youngest occupied entry whose adr equals `ld_adr`. If no entry matches, `ld_value = rvalue`.
  - Youngest means closest to tail, counting backward from tail−1 to head.
  - The entry currently being drained still participates in forwarding until it pops.
  - A store presented on `st_*` in the same cycle is not forwarded.
- **Ordering.** Stores reach RAM strictly in acceptance order. Duplicate addresses are not merged; each store is written.
- **Reset.** Asynchronous, mid-operation included. Pointers and `count` go to 0, and pending stores are discarded, never written.
  - Outputs under reset: `st_ready`=1, `empty`=1, `count`=0, `wenable`=0, `wadr`=0, `wvalue`=0.
  - `ld_value` = `rvalue` because no entries are valid.

## Timing
- Store accepted at posedge k:
  - Occupies the head at k if the buffer was empty.
  - `wenable` is high during cycle k→k+1, the RAM writes at the negedge inside that cycle, and the entry pops at posedge k+1.
- Throughput is 1 store/cycle in and 1 store/cycle out. With no hold, a buffer in steady state never fills.
- `hold` takes effect combinationally. The entry stays at head and `count` does not decrement.
- `st_ready`, `empty`, and `count` are functions of registered state only. They are valid from posedge and do not depend on `st_valid`.
- The `ld_adr`→`ld_value` path is combinational through the comparators and RAM read.

## Test plan
- **Single store then load.** After reset, push (adr 0x10, value 0xDEADBEEF) with `hold`=0.
  - Next cycle: `wenable`=1, `wadr`=0x10.
  - Load of 0x10 returns 0xDEADBEEF in both cycles, first forwarded and then from RAM.
  - `empty`=1 after the pop.
- **Fill and full.** With `hold`=1, push 4 stores to adr 0..3, values 0xA0..0xA3.
  - `count`=4 and `st_ready`=0.
  - A fifth `st_valid` (adr 9) is ignored.
  - Release `hold`: writes appear in order 0,1,2,3 on consecutive cycles.
  - Adr 9 is never written.
- **Youngest-wins forwarding.** With `hold`=1, push (adr 5, 0x1), then (adr 5, 0x2), then (adr 6, 0x3).
  - Load 5 → 0x2; load 6 → 0x3; load 7 → RAM content.
  - After draining, RAM[5]=0x2.
- **Simultaneous push/pop and wrap-around.** Stream 10 back-to-back stores with `hold`=0.
  - `count` stays at 1.
  - Pointers wrap past `DEPTH`.
  - RAM receives all 10 stores in order.
- **Reset mid-drain.** With `hold`=1, queue 3 stores, then pulse `reset` asynchronously between clock edges.
  - Outputs take their reset values immediately.
  - None of the 3 stores reach RAM.
  - `st_ready`=1.
